// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
//
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH multiplier controller. A single shared
// add datapath is stepped over WIDTH iterations. A start/busy/done handshake
// controls it, and the product is held until the next accepted start.
//
// Build option (macro SEQ_MULT_SIGNED_EN):
//   defined     : signed radix-2 Booth operation. M is sign-extended, the shift
//                 is arithmetic, and subtraction adds (~M + 1).
//   not defined : unsigned shift-add operation. M is zero-extended, and the
//                 carry in acc[WIDTH] is shifted down by a logical shift.
//   Handshake, latency and reset behaviour are identical in both builds.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   start    in   multiply request; sampled only in IDLE
//   op_a     in   [WIDTH-1:0]   multiplicand M, captured on accepted start
//   op_b     in   [WIDTH-1:0]   multiplier Q, captured on accepted start
//   busy     out  high while iterating (CALC state)
//   done     out  one-cycle pulse when product is valid
//   product  out  [2*WIDTH-1:0] result, held until the next accepted start
//
// Timing: start is sampled at edge k. CALC iterates on edges k+1..k+WIDTH.
// DONE registers the product at edge k+WIDTH+1, so done is high in the cycle
// that follows that edge.
// -----------------------------------------------------------------------------
module seq_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

    logic [1:0]         state_reg;
    logic [WIDTH:0]     m_reg;
    logic [WIDTH:0]     acc_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] product_reg;

    logic [WIDTH:0]     m_ext;      // operand A extended to accumulator width
    logic [WIDTH:0]     addend;     // selected value added to acc this iteration
    logic [WIDTH:0]     acc_sum;    // acc + addend, carry-out discarded
    logic               shift_fill; // bit shifted into acc[WIDTH] on the shift

`ifdef SEQ_MULT_SIGNED_EN
    logic q_m1_reg;

    assign m_ext = {op_a[WIDTH-1], op_a};

    // Booth recoding of {Q[0], q_m1}. 10 subtracts M as an add of ~M + 1.
    // The extra accumulator bit keeps -(-2^(WIDTH-1)) representable.
    always_comb begin
        addend = '0;
        case ({q_reg[0], q_m1_reg})
            2'b01:   addend = m_reg;
            2'b10:   addend = (~m_reg) + ONE_EXT;
            default: addend = '0;
        endcase
    end

    // Arithmetic shift: replicate the sign of the freshly summed accumulator.
    assign shift_fill = acc_sum[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m1_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            q_m1_reg <= 1'b0;
        end else if (state_reg == CALC) begin
            q_m1_reg <= q_reg[0];
        end
    end
`else
    assign m_ext = {1'b0, op_a};

    always_comb begin
        addend = '0;
        if (q_reg[0]) begin
            addend = m_reg;
        end
    end

    // Logical shift. The carry out of the WIDTH-bit add is held in
    // acc_sum[WIDTH] and moves down into acc[WIDTH-1]. A zero enters at the top.
    assign shift_fill = 1'b0;
`endif

    assign acc_sum = acc_reg + addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            m_reg       <= '0;
            acc_reg     <= '0;
            q_reg       <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        m_reg     <= m_ext;
                        q_reg     <= op_b;
                        acc_reg   <= '0;
                        count_reg <= CNT_INIT;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    // {acc, Q} shift right by one as a single register.
                    acc_reg   <= {shift_fill, acc_sum[WIDTH:1]};
                    q_reg     <= {acc_sum[0], q_reg[WIDTH-1:1]};
                    count_reg <= count_reg - CNT_LAST;
                    if (count_reg == CNT_LAST) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // A start seen here is intentionally dropped.
                    product_reg <= {acc_reg[WIDTH-1:0], q_reg};
                    done_reg    <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_reg == CALC);
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_ctrl
//
// Bench for seq_mult_ctrl. It drives directed and random multiplies and checks
// busy, done and product on every cycle of each operation. The expected
// product comes from native 64-bit arithmetic: signed when SEQ_MULT_SIGNED_EN
// is defined, unsigned otherwise.
// -----------------------------------------------------------------------------
module tb_seq_mult_ctrl;

    localparam int WIDTH = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              busy;
    logic              done;
    logic [2*WIDTH-1:0] product;

    int vectors;
    int miscompares;
    logic [63:0] prev_product;

    seq_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MULT_SIGNED_EN
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
`else
        logic [63:0] ua;
        logic [63:0] ub;
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation. The bench samples on negedges. Cycle c is the
    // negedge after edge k+c, where edge k is the edge that accepts start.
    // With inject=1, it pulses start with other operands during CALC and
    // during DONE. Neither pulse should have any effect.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [63:0] exp;
        exp = ref_mul(a, b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b0;
                op_a  = $urandom;
                op_b  = $urandom;
            end
            if (inject && (c == 10 || c == 32)) begin
                start = 1'b1;
                op_a  = 32'd9;
                op_b  = 32'd9;
            end
            if (inject && (c == 11 || c == 33)) begin
                start = 1'b0;
            end
            check("busy", {63'b0, busy}, {63'b0, (c < 32)});
            check("done", {63'b0, done}, {63'b0, (c == 33)});
            check("product", product, (c >= 33) ? exp : prev_product);
        end
        prev_product = exp;
        $display("op a=%h b=%h product=%h expected=%h", a, b, product, exp);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        prev_product = 64'd0;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;

        #3;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd6, 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(32'd2, 32'd4, 1'b1);
        run_op(32'd9, 32'd9, 1'b0);

        // Reset during CALC cycle 17 must clear every output immediately.
        @(negedge clk);
        op_a  = 32'd5;
        op_b  = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_rst_busy", {63'b0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {63'b0, busy}, 64'd0);
        check("async_rst_done", {63'b0, done}, 64'd0);
        check("async_rst_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_product = 64'd0;
        @(negedge clk);
        check("post_rst_busy", {63'b0, busy}, 64'd0);
        check("post_rst_done", {63'b0, done}, 64'd0);
        $display("reset applied during CALC cycle 17");
        run_op(32'd10, 32'd10, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_op($urandom, $urandom, (i % 4) == 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
Multi-cycle 32x32->64 multiplier controller for the KGP_RISC execute stage. It sequences one shared add/subtract datapath over WIDTH iterations using radix-2 Booth recoding. Subtraction is performed as an add of the two's complement of the multiplicand (~M + 1). The ALU starts it with a start/busy/done handshake and reads a 64-bit product that is held until the next accepted start.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
op_a  input  WIDTH  multiplicand M; captured on the accepted start edge
op_b  input  WIDTH  multiplier Q; captured on the accepted start edge
busy  output  1  high while an operation is in flight (CALC state)
done  output  1  single-cycle pulse when product is valid
product  output  2*WIDTH  result; held stable from done until the next accepted start

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, acc=0, Q=0, q_m1=0, count=0.
- States:
  - IDLE: on start=1, latch M (sign-extended to WIDTH+1 bits), Q=op_b, acc=0, q_m1=0, count=WIDTH; go to CALC. Otherwise stay in IDLE.
  - CALC: busy=1. Each cycle, decode {Q[0],q_m1}:
    - 01: acc += M
    - 10: acc += (~M + 1)
    - 00 or 11: acc unchanged
  - CALC (continued): after the add, arithmetic-shift {acc,Q,q_m1} right by 1 as one register, then count -= 1. When count reaches 1 on the current cycle, the next state is DONE.
  - DONE: busy=0, done=1 for exactly one cycle, product = {acc[WIDTH-1:0], Q}; then go to IDLE. start is ignored in DONE.
- Accumulator width: acc is WIDTH+1 bits. This makes negating M = -2^(WIDTH-1) exact, with no overflow. Adder carry-out is discarded.
- Latency: start sampled at edge k. CALC occupies edges k+1..k+WIDTH. done is high in the cycle after edge k+WIDTH+1. Throughput is one result per WIDTH+2 cycles.
- start while busy or done: ignored. Operands are not re-captured and product is not disturbed.
- op_a/op_b changes after the accepted start edge: no effect on the result.
- Reset mid-operation: immediate return to reset values. A later start begins a fresh operation; no partial result is ever exposed.
- product changes only on DONE entry or on reset.

Optional Feature:
Macro SEQ_MULT_SIGNED_EN.
- Defined: signed Booth operation as described under Behaviour; M is sign-extended and shifts are arithmetic.
- Not defined: unsigned shift-add operation:
  - M is zero-extended to WIDTH+1 bits.
  - In CALC, if Q[0]=1 then acc += M, else acc is unchanged.
  - The shift is logical, with acc[WIDTH] (the carry) shifted in from the top.
  - q_m1 is unused.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
1. Signed build; op_a=3, op_b=5, start for one cycle -> busy high for 32 cycles, then done pulse; product=0x0000_0000_0000_000F.
2. Signed build; op_a=-7 (0xFFFFFFF9), op_b=6 -> product=0xFFFF_FFFF_FFFF_FFD6 (-42). Repeat with op_a=0x7FFFFFFF, op_b=-1 -> 0xFFFF_FFFF_8000_0001.
3. Signed build; op_a=op_b=0x80000000 -> product=0x4000_0000_0000_0000, with no overflow from negating M.
4. Unsigned build; op_a=op_b=0xFFFFFFFF -> product=0xFFFF_FFFE_0000_0001; latency identical to the signed build (done 33 edges after the start edge).
5. Start 2*4, then pulse start with op_a=9, op_b=9 at CALC cycle 10 and during DONE -> those starts are ignored; product=8; next start accepted from IDLE yields 81.
6. Assert rst at CALC cycle 17, release, start 10*10 -> busy, done and product clear asynchronously on reset; new result 100 after the normal latency with no stale done pulse.
